// File: rtl/adpll_acq_ctrl.sv
// adpll_acq_ctrl: acquisition / lock sequencer for the ADPLL.
//
// Sweeps base_freq from f_start towards f_stop in f_step increments. Each step pulses pll_rst
// for one clock, waits SETTLE_N enabled samples, then averages |ph_err| over windows of
// 2**WIN_LOG2 enabled samples. LOCK_WINS consecutive good windows declare lock. While locked,
// UNLOCK_WINS consecutive bad windows drop lock and restart the sweep from f_start.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   en            sample strobe; every counter, the accumulator and all decisions advance on en
//   start, abort  1-cycle command pulses (abort wins)
//   f_start       signed sweep start word
//   f_stop        signed sweep end word
//   f_step        unsigned sweep increment
//   lock_thr      window is good in MEASURE when mean < lock_thr
//   unlock_thr    window is bad in LOCKED when mean >= unlock_thr
//   ph_err        signed filtered phase error
//   base_freq     signed frequency word to the ADPLL
//   pll_rst       active-high loop reset
//   locked        lock indication
//   busy          high while settling or measuring
//   fail          sweep exhausted without lock (sticky until start/abort)
//   win_mag       mean |ph_err| of the last completed window
//
// Configuration macro: ADPLL_ACQ_WRAP_EN
//   defined     -> an exhausted sweep restarts from f_start; fail never asserts
//   undefined   -> an exhausted sweep parks in FAIL
module adpll_acq_ctrl #(
  parameter int unsigned PW          = 24,
  parameter int unsigned DW          = 12,
  parameter int unsigned WIN_LOG2    = 8,
  parameter int unsigned SETTLE_N    = 512,
  parameter int unsigned LOCK_WINS   = 4,
  parameter int unsigned UNLOCK_WINS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [PW-1:0] f_start,
  input  logic signed [PW-1:0] f_stop,
  input  logic        [PW-1:0] f_step,
  input  logic        [DW-2:0] lock_thr,
  input  logic        [DW-2:0] unlock_thr,
  input  logic signed [DW-1:0] ph_err,
  output logic signed [PW-1:0] base_freq,
  output logic                 pll_rst,
  output logic                 locked,
  output logic                 busy,
  output logic                 fail,
  output logic        [DW-2:0] win_mag
);

  // Accumulator holds 2**WIN_LOG2 samples of at most 2**(DW-1)-1 each, so it cannot overflow.
  localparam int unsigned AW = DW - 1 + WIN_LOG2;
  localparam int unsigned SW = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam int unsigned GW = (LOCK_WINS > 1) ? $clog2(LOCK_WINS) : 1;
  localparam int unsigned BW = (UNLOCK_WINS > 1) ? $clog2(UNLOCK_WINS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeasure,
    StLocked,
    StFail
  } state_e;

  state_e              state;
  logic [SW-1:0]       settle_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [GW-1:0]       good_cnt;
  logic [BW-1:0]       bad_cnt;
  logic [AW-1:0]       acc;

  logic        [DW-1:0] err_neg;
  logic        [DW-2:0] err_abs;
  logic        [AW-1:0] acc_sum;
  logic        [DW-2:0] win_mean;
  logic                 win_done;
  logic                 settle_done;
  logic                 win_good;
  logic                 win_bad;
  logic signed [PW:0]   nxt;
  logic signed [PW:0]   stop_ext;
  logic                 past_stop;

  always_comb begin
    err_neg = -ph_err;
    // The most negative code has no positive twin; clamp it to the largest magnitude.
    if (ph_err == {1'b1, {(DW-1){1'b0}}}) begin
      err_abs = '1;
    end else if (ph_err[DW-1]) begin
      err_abs = err_neg[DW-2:0];
    end else begin
      err_abs = ph_err[DW-2:0];
    end

    acc_sum     = acc + {{WIN_LOG2{1'b0}}, err_abs};
    win_mean    = acc_sum[AW-1:WIN_LOG2];
    win_done    = en && (win_cnt == {WIN_LOG2{1'b1}});
    settle_done = en && (settle_cnt == SW'(SETTLE_N - 1));
    win_good    = win_mean < lock_thr;
    win_bad     = win_mean >= unlock_thr;

    // One extra bit so base_freq + f_step can be compared against f_stop without wrapping.
    nxt       = {base_freq[PW-1], base_freq} + {1'b0, f_step};
    stop_ext  = {f_stop[PW-1], f_stop};
    past_stop = nxt > stop_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      base_freq  <= '0;
      pll_rst    <= 1'b1;
      locked     <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
      win_mag    <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      acc        <= '0;
    end else if (abort) begin
      // base_freq and win_mag are deliberately held.
      state      <= StIdle;
      pll_rst    <= 1'b1;
      locked     <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      acc        <= '0;
    end else begin
      case (state)
        StIdle, StFail: begin
          if (start) begin
            state      <= StSettle;
            base_freq  <= f_start;
            pll_rst    <= 1'b1;
            busy       <= 1'b1;
            fail       <= 1'b0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            acc        <= '0;
          end
        end

        StSettle: begin
          // The reset pulse lasts exactly the first SETTLE cycle, independent of en.
          pll_rst <= 1'b0;
          if (settle_done) begin
            state      <= StMeasure;
            settle_cnt <= '0;
          end else if (en) begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        StMeasure: begin
          if (win_done) begin
            win_mag <= win_mean;
            acc     <= '0;
            win_cnt <= '0;
            if (win_good) begin
              if (good_cnt == GW'(LOCK_WINS - 1)) begin
                state    <= StLocked;
                locked   <= 1'b1;
                busy     <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else begin
              good_cnt <= '0;
              if (past_stop) begin
`ifdef ADPLL_ACQ_WRAP_EN
                state      <= StSettle;
                base_freq  <= f_start;
                pll_rst    <= 1'b1;
                settle_cnt <= '0;
`else
                state      <= StFail;
                fail       <= 1'b1;
                busy       <= 1'b0;
                pll_rst    <= 1'b1;
`endif
              end else begin
                state      <= StSettle;
                base_freq  <= nxt[PW-1:0];
                pll_rst    <= 1'b1;
                settle_cnt <= '0;
              end
            end
          end else if (en) begin
            acc     <= acc_sum;
            win_cnt <= win_cnt + WIN_LOG2'(1);
          end
        end

        StLocked: begin
          if (win_done) begin
            win_mag <= win_mean;
            acc     <= '0;
            win_cnt <= '0;
            if (win_bad) begin
              if (bad_cnt == BW'(UNLOCK_WINS - 1)) begin
                // Lost lock: full re-sweep from the start frequency.
                state      <= StSettle;
                locked     <= 1'b0;
                busy       <= 1'b1;
                base_freq  <= f_start;
                pll_rst    <= 1'b1;
                settle_cnt <= '0;
                bad_cnt    <= '0;
                good_cnt   <= '0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end else begin
              bad_cnt <= '0;
            end
          end else if (en) begin
            acc     <= acc_sum;
            win_cnt <= win_cnt + WIN_LOG2'(1);
          end
        end

        default: begin
          state   <= StIdle;
          pll_rst <= 1'b1;
          busy    <= 1'b0;
          locked  <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

endmodule
